// File: rtl/id_issue_pkg.sv
// id_issue_pkg: shared types and helpers for the ID/EX issue stage
package id_issue_pkg;
  localparam int N_DEF = 32;
  localparam int L_DEF = 8;
  localparam int V_DEF = 20;
  typedef struct packed {
    logic       alu_src;
    logic       set_flags;
    logic       mem_we;
    logic       wb_sel;
    logic       op_src;
    logic [1:0] alu_ctrl;
    logic [1:0] branch_sel;
    logic [1:0] op_type;
  } ctrl_t;
  typedef logic [V_DEF-1:0][L_DEF-1:0] lanes_t;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write counters with RAW/WAW hazard detection
module id_scoreboard
  import id_issue_pkg::*;
#(
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_a,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_a,
  input  logic          undo,
  input  logic [AW-1:0] undo_a,
  input  logic [AW-1:0] qa1,
  input  logic [AW-1:0] qa2,
  output logic          hazard,
  output logic          wbhit1,
  output logic          wbhit2,
  output logic          sb_error
);
  localparam int NR = 2 ** AW;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  logic [CNT_W-1:0] cnt [NR];
  logic wbhit3, spur;
  function automatic logic src_haz(input logic [CNT_W-1:0] c, input logic hit);
    return (c > CNT_W'(1)) | ((c == CNT_W'(1)) & !hit);
  endfunction
  // a write-back only retires a pending write if one exists; clamping guards a combined wb+undo
  function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] c, input logic inc, input logic d1,
                                            input logic d2);
    logic [CNT_W+1:0] s, d;
    s = {2'b00, c} + {{(CNT_W+1){1'b0}}, inc};
    d = {{(CNT_W+1){1'b0}}, d1 & (c != '0)} + {{(CNT_W+1){1'b0}}, d2};
    return (s < d) ? '0 : s[CNT_W-1:0] - d[CNT_W-1:0];
  endfunction
  assign wbhit1 = wb_we & (wb_a == qa1);
  assign wbhit2 = wb_we & (wb_a == qa2);
  assign wbhit3 = wb_we & (wb_a == iss_a);
  assign hazard = src_haz(cnt[qa1], wbhit1) | src_haz(cnt[qa2], wbhit2) |
                  (iss_we & (cnt[iss_a] == MAX) & !wbhit3);
  assign spur = wb_we & (cnt[wb_a] == '0) & !(issue & iss_we & (iss_a == wb_a));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) cnt[r] <= '0;
      sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NR; r++)
        cnt[r] <= step(cnt[r], issue & iss_we & (iss_a == AW'(r)), wb_we & (wb_a == AW'(r)),
                       undo & (undo_a == AW'(r)));
      if (spur) sb_error <= 1'b1;
    end
  end
endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: ID/EX register with handshake, flush, scoreboard stall and write-back bypass
module id_issue_stage
  import id_issue_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int L      = L_DEF,
  parameter int V      = V_DEF,
  parameter int AW     = 5,
  parameter int CNT_W  = 2,
  parameter int CTRL_W = $bits(ctrl_t)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [AW-1:0]     A1_i,
  input  logic [AW-1:0]     A2_i,
  input  logic [AW-1:0]     A3_i,
  input  logic              RegFile_WE_i,
  input  logic [CTRL_W-1:0] Ctrl_i,
  input  logic [N-1:0]      Extend_i,
  input  logic [N-1:0]      RD1_S_i,
  input  logic [N-1:0]      RD2_S_i,
  input  logic [V*L-1:0]    RD1_V_i,
  input  logic [V*L-1:0]    RD2_V_i,
  input  logic              RFWE_WB,
  input  logic [AW-1:0]     A3_WB,
  input  logic [N-1:0]      WD3_SCA_WB,
  input  logic [V*L-1:0]    WD3_VEC_WB,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N-1:0]      RD1_S_o,
  output logic [N-1:0]      RD2_S_o,
  output logic [N-1:0]      Extend_o,
  output logic [V*L-1:0]    RD1_V_o,
  output logic [V*L-1:0]    RD2_V_o,
  output logic [AW-1:0]     A3_o,
  output logic              RegFile_WE_o,
  output logic [CTRL_W-1:0] Ctrl_o,
  output logic              stall_o,
  output logic              sb_error_o
);
  logic hazard, hit1, hit2, issue;
  assign ready_o = !flush_i & !hazard & (!valid_o | ready_i);
  assign issue   = valid_i & ready_o;
  assign stall_o = valid_i & !ready_o;
  id_scoreboard #(.AW(AW), .CNT_W(CNT_W)) u_sb (
    .clk(CLK), .rst(RST), .issue(issue), .iss_we(RegFile_WE_i), .iss_a(A3_i),
    .wb_we(RFWE_WB), .wb_a(A3_WB), .undo(flush_i & valid_o & RegFile_WE_o), .undo_a(A3_o),
    .qa1(A1_i), .qa2(A2_i), .hazard(hazard), .wbhit1(hit1), .wbhit2(hit2), .sb_error(sb_error_o)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_o      <= 1'b0;
      RD1_S_o      <= '0;
      RD2_S_o      <= '0;
      Extend_o     <= '0;
      RD1_V_o      <= '0;
      RD2_V_o      <= '0;
      A3_o         <= '0;
      RegFile_WE_o <= 1'b0;
      Ctrl_o       <= '0;
    end else if (issue) begin
      valid_o      <= 1'b1;
      RD1_S_o      <= hit1 ? WD3_SCA_WB : RD1_S_i;
      RD2_S_o      <= hit2 ? WD3_SCA_WB : RD2_S_i;
      RD1_V_o      <= hit1 ? WD3_VEC_WB : RD1_V_i;
      RD2_V_o      <= hit2 ? WD3_VEC_WB : RD2_V_i;
      Extend_o     <= Extend_i;
      A3_o         <= A3_i;
      RegFile_WE_o <= RegFile_WE_i;
      Ctrl_o       <= Ctrl_i;
    end else if (flush_i | ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
Parametrised successor to the fixed ID/EX pipe register. It sits between decode (register-file read, control unit, extend) and execute. It adds a valid/ready handshake, flush, a per-register pending-write scoreboard with RAW/WAW stall, and write-back bypass of both scalar and vector read data. Write-backs always arrive in issue order.

Parameters:
N, 32, scalar data width
L, 8, vector lane width
V, 20, vector lane count
AW, 5, register address width (2**AW registers tracked)
CNT_W, 2, pending-write counter width per register
CTRL_W, 11, packed control bundle width (ALUSource, SetFlags, MemWE, WBSelect, OpSource, ALUControl[2], BranchSelect[2], OpType[2])

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
valid_i  in  1  decoded instruction present
ready_o  out  1  stage accepts instruction this cycle
flush_i  in  1  kill ID/EX contents, block issue
A1_i, A2_i, A3_i  in  AW  source/destination addresses
RegFile_WE_i  in  1  instruction writes A3_i
Ctrl_i  in  CTRL_W  control bundle
Extend_i  in  N  extended immediate
RD1_S_i, RD2_S_i  in  N  register-file scalar reads
RD1_V_i, RD2_V_i  in  V*L  register-file vector reads
RFWE_WB  in  1  write-back enable
A3_WB  in  AW  write-back address
WD3_SCA_WB  in  N  write-back scalar data
WD3_VEC_WB  in  V*L  write-back vector data
valid_o  out  1  EX slot holds valid instruction
ready_i  in  1  EX consumes slot
RD1_S_o, RD2_S_o, Extend_o  out  N  registered operands
RD1_V_o, RD2_V_o  out  V*L  registered vector operands
A3_o  out  AW; RegFile_WE_o  out  1; Ctrl_o  out  CTRL_W  registered fields
stall_o  out  1  valid_i & !ready_o
sb_error_o  out  1  sticky: write-back to a register with count 0

Behaviour:
- Reset: valid_o=0. All data, address and control outputs = 0. All counters = 0. sb_error_o = 0. Reset mid-operation discards the slot and scoreboard in the same edge.
- wbhit(a) = RFWE_WB & (A3_WB==a).
- Source hazard(a) = cnt[a]>1, or (cnt[a]==1 & !wbhit(a)). A1 and A2 are always checked; the mode bits do not mask the check.
- WAW/saturation hazard = RegFile_WE_i & cnt[A3_i]==2**CNT_W-1 & !wbhit(A3_i).
- ready_o = !flush_i & !hazard & (!valid_o | ready_i). Combinational; it never depends on valid_i.
- issue = valid_i & ready_o. On issue, every output register loads next edge and valid_o=1.
- Operand select: if wbhit(A1_i), RD1_S_o/RD1_V_o take WD3_SCA_WB/WD3_VEC_WB; otherwise they take the RF read. A2 is handled identically. Latency is 1 cycle.
- valid_o & ready_i & !issue: valid_o=0 next edge. Data outputs hold their last value.
- valid_o & !ready_i: all outputs hold.
- flush_i: valid_o=0 next edge and no issue. If valid_o & RegFile_WE_o, cnt[A3_o] is decremented (undo).
- Counter update per register r, combined in a single edge:
  - +1 on issue with RegFile_WE_i & A3_i==r.
  - -1 on wbhit(r) when cnt[r]>0.
  - -1 on flush undo of r.
  - Simultaneous +1/-1 leaves the counter unchanged. The counter never wraps.
- Write-back with cnt[A3_WB]==0 (and no same-cycle increment): counter stays 0 and sb_error_o sets until RST.

Decomposition:
- Package id_issue_pkg:
  - ctrl_t packed struct (CTRL_W bits, field order as listed above).
  - CNT_MAX constant function.
  - lane-vector typedef logic [V-1:0][L-1:0].
- Sub-module id_scoreboard: holds the counters. Ports: issue/A3/WE, WB, flush-undo, query addresses. Outputs: hazard bits and error.

Test Plan:
- Back-to-back independent issue: A1=3, A2=4, A3=5, then A1=6, A3=7, ready_i=1 → valid_o high two consecutive cycles, ready_o=1 throughout, RD1_S_o=RF[3] then RF[6].
- RAW stall and release: issue A3=5 WE; next instruction A1=5 → stall_o=1 until RFWE_WB with A3_WB=5, WD3_SCA_WB=0xABCD. In that cycle ready_o=1 and RD1_S_o=0xABCD next edge (bypass); cnt[5] returns to 0.
- EX backpressure: ready_i=0 for 3 cycles with valid_o=1 → outputs constant, ready_o=0, no counter change; ready_i=1 → next instruction loads.
- Flush: issue A3=9 WE, then flush_i=1 → valid_o=0 next edge, cnt[9]=0, and a following read of r9 does not stall.
- Saturation (CNT_W=2): three issues to A3=2 with no write-back → fourth WE to r2 stalls; one WB to r2 → the fourth issues in that cycle.
- Spurious WB to r10 with cnt=0 → sb_error_o=1 and stays high; RST mid-stall → valid_o=0, sb_error_o=0, ready_o=1 next cycle.
